// File: rtl/vga_timing_pipe_if.sv
// vga_timing_pipe_if: pixel-store read bus plus video DAC outputs.
// master = timing pipe (drives x/y/sync/colour), slave = store/DAC side.
// With VGA_TEST_PATTERN_EN defined, pattern_sel is added.
interface vga_timing_pipe_if #(
  parameter int CNT_W = 10,
  parameter int CW    = 4
);
  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic             rd_active;
  logic [CW-1:0]    pix_r;
  logic [CW-1:0]    pix_g;
  logic [CW-1:0]    pix_b;
  logic             hsync;
  logic             vsync;
  logic             blank_b;
  logic [CW-1:0]    r_out;
  logic [CW-1:0]    g_out;
  logic [CW-1:0]    b_out;
  logic             sof;
  logic             sol;
  logic [7:0]       frame_cnt;
`ifdef VGA_TEST_PATTERN_EN
  logic             pattern_sel;
`endif

  modport master (
    output x, y, rd_active,
    input  pix_r, pix_g, pix_b,
`ifdef VGA_TEST_PATTERN_EN
    input  pattern_sel,
`endif
    output hsync, vsync, blank_b,
    output r_out, g_out, b_out,
    output sof, sol, frame_cnt
  );

  modport slave (
    input  x, y, rd_active,
    output pix_r, pix_g, pix_b,
`ifdef VGA_TEST_PATTERN_EN
    output pattern_sel,
`endif
    input  hsync, vsync, blank_b,
    input  r_out, g_out, b_out,
    input  sof, sol, frame_cnt
  );
endinterface

// File: rtl/vga_timing_pipe.sv
// vga_timing_pipe: VGA h/v counters, pixel-store addressing, sync/blank
// realignment with PIPE_LAT-late pixel data, blanked colour to the DAC.
// Ports: clk, reset (async, active-high), pix_en (clock enable),
//   bus (vga_timing_pipe_if.master): x/y/rd_active out, pix_* in,
//   hsync/vsync/blank_b/r,g,b_out/sof/sol/frame_cnt out.
// Option: VGA_TEST_PATTERN_EN adds pattern_sel -> 64-pixel colour bars.
module vga_timing_pipe #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int PIPE_LAT  = 1,
  parameter int CW        = 4,
  parameter int CNT_W     = 10
) (
  input logic clk,
  input logic reset,
  input logic pix_en,
  vga_timing_pipe_if.master bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic HP = 1'(HSYNC_POL);
  localparam logic VP = 1'(VSYNC_POL);

  typedef struct packed {
    logic sof;
    logic sol;
    logic blk;
    logic vs;
    logic hs;
  } fl_t;

  logic [CNT_W-1:0] r_x;
  logic [CNT_W-1:0] r_y;
  logic             w_x_last;
  logic             w_y_last;
  logic             w_rd_active;
  fl_t              w_fl_raw;
  fl_t              w_fl_dly;
  logic [CW-1:0]    w_col_r;
  logic [CW-1:0]    w_col_g;
  logic [CW-1:0]    w_col_b;

  logic             r_hsync;
  logic             r_vsync;
  logic             r_blank;
  logic [CW-1:0]    r_r;
  logic [CW-1:0]    r_g;
  logic [CW-1:0]    r_b;
  logic             r_sof;
  logic             r_sol;
  logic [7:0]       r_frame;

  assign w_x_last = (r_x == CNT_W'(H_TOTAL - 1));
  assign w_y_last = (r_y == CNT_W'(V_TOTAL - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x <= '0;
      r_y <= '0;
    end else if (pix_en) begin
      if (w_x_last) begin
        r_x <= '0;
        r_y <= w_y_last ? '0 : r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  assign w_rd_active = (r_x < CNT_W'(H_ACTIVE)) &&
                       (r_y < CNT_W'(V_ACTIVE));

  // Flags are kept active-high through the delay line; polarity is
  // applied only at the output register.
  always_comb begin
    w_fl_raw     = '0;
    w_fl_raw.hs  = (r_x >= CNT_W'(H_ACTIVE + H_FP)) &&
                   (r_x <  CNT_W'(H_ACTIVE + H_FP + H_SYNC));
    w_fl_raw.vs  = (r_y >= CNT_W'(V_ACTIVE + V_FP)) &&
                   (r_y <  CNT_W'(V_ACTIVE + V_FP + V_SYNC));
    w_fl_raw.blk = w_rd_active;
    w_fl_raw.sof = (r_x == '0) && (r_y == '0);
    w_fl_raw.sol = (r_x == '0);
  end

  generate
    if (PIPE_LAT > 0) begin : g_fl_dly
      fl_t r_sr [PIPE_LAT];
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < PIPE_LAT; i++) r_sr[i] <= '0;
        end else if (pix_en) begin
          r_sr[0] <= w_fl_raw;
          for (int i = 1; i < PIPE_LAT; i++) r_sr[i] <= r_sr[i-1];
        end
      end
      assign w_fl_dly = r_sr[PIPE_LAT-1];
    end else begin : g_fl_nodly
      assign w_fl_dly = w_fl_raw;
    end
  endgenerate

`ifdef VGA_TEST_PATTERN_EN
  logic [CNT_W-1:0] w_xd;
  logic [CNT_W+8:0] w_xd_ext;
  logic [2:0]       w_bar;

  generate
    if (PIPE_LAT > 0) begin : g_x_dly
      logic [CNT_W-1:0] r_xs [PIPE_LAT];
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < PIPE_LAT; i++) r_xs[i] <= '0;
        end else if (pix_en) begin
          r_xs[0] <= r_x;
          for (int i = 1; i < PIPE_LAT; i++) r_xs[i] <= r_xs[i-1];
        end
      end
      assign w_xd = r_xs[PIPE_LAT-1];
    end else begin : g_x_nodly
      assign w_xd = r_x;
    end
  endgenerate

  // Zero-extend so narrow CNT_W still yields a defined bar index.
  assign w_xd_ext = {9'd0, w_xd};
  assign w_bar    = w_xd_ext[8:6];
  assign w_col_r  = bus.pattern_sel ? {CW{w_bar[2]}} : bus.pix_r;
  assign w_col_g  = bus.pattern_sel ? {CW{w_bar[1]}} : bus.pix_g;
  assign w_col_b  = bus.pattern_sel ? {CW{w_bar[0]}} : bus.pix_b;
`else
  assign w_col_r = bus.pix_r;
  assign w_col_g = bus.pix_g;
  assign w_col_b = bus.pix_b;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hsync <= ~HP;
      r_vsync <= ~VP;
      r_blank <= 1'b0;
      r_r     <= '0;
      r_g     <= '0;
      r_b     <= '0;
      r_sof   <= 1'b0;
      r_sol   <= 1'b0;
      r_frame <= '0;
    end else if (pix_en) begin
      r_hsync <= w_fl_dly.hs ? HP : ~HP;
      r_vsync <= w_fl_dly.vs ? VP : ~VP;
      r_blank <= w_fl_dly.blk;
      r_r     <= w_col_r & {CW{w_fl_dly.blk}};
      r_g     <= w_col_g & {CW{w_fl_dly.blk}};
      r_b     <= w_col_b & {CW{w_fl_dly.blk}};
      r_sof   <= w_fl_dly.sof;
      r_sol   <= w_fl_dly.sol;
      if (w_fl_dly.sof) r_frame <= r_frame + 8'd1;
    end
  end

  assign bus.x         = r_x;
  assign bus.y         = r_y;
  assign bus.rd_active = w_rd_active;
  assign bus.hsync     = r_hsync;
  assign bus.vsync     = r_vsync;
  assign bus.blank_b   = r_blank;
  assign bus.r_out     = r_r;
  assign bus.g_out     = r_g;
  assign bus.b_out     = r_b;
  assign bus.sof       = r_sof;
  assign bus.sol       = r_sol;
  assign bus.frame_cnt = r_frame;

endmodule

// File: tb/tb_vga_timing_pipe.sv
// tb_vga_timing_pipe: random stall/colour stimulus on a shrunk raster,
// outputs compared to an index-arithmetic model of the raster.
module tb_vga_timing_pipe;

  localparam int HA = 8, HF = 1, HS = 2, HB = 1;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FR = HT * VT;
  localparam int P  = 3;
  localparam int CW = 4;
  localparam int NCYC = 40000;

  logic clk = 1'b0;
  logic reset;
  logic pix_en;
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_fail = 0;
  int   n;
  logic [11:0] mem [FR];

  vga_timing_pipe_if #(.CNT_W(10), .CW(CW)) bus ();

  vga_timing_pipe #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(0), .VSYNC_POL(0), .PIPE_LAT(P),
    .CW(CW), .CNT_W(10)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pix_en(pix_en),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s n=%0d got=%0d exp=%0d", tag, n, got, exp);
    end
  endtask

  task automatic check_all();
    int m, xm, ym;
    logic [11:0] c;
    bit act_h, act_v, vis;
    chk("x", int'(bus.x), n % HT);
    chk("y", int'(bus.y), (n / HT) % VT);
    chk("rd_active", int'(bus.rd_active),
        int'(((n % HT) < HA) && (((n / HT) % VT) < VA)));
    m = n - P - 1;
    if (m < 0) begin
      chk("hsync_fill", int'(bus.hsync), 1);
      chk("vsync_fill", int'(bus.vsync), 1);
      chk("blank_fill", int'(bus.blank_b), 0);
      chk("r_fill", int'(bus.r_out), 0);
      chk("sof_fill", int'(bus.sof), 0);
      chk("sol_fill", int'(bus.sol), 0);
      chk("frame_fill", int'(bus.frame_cnt), 0);
    end else begin
      xm = m % HT;
      ym = (m / HT) % VT;
      act_h = (xm >= HA + HF) && (xm < HA + HF + HS);
      act_v = (ym >= VA + VF) && (ym < VA + VF + VS);
      vis = (xm < HA) && (ym < VA);
      c = vis ? mem[ym*HT + xm] : 12'h000;
      chk("hsync", int'(bus.hsync), int'(!act_h));
      chk("vsync", int'(bus.vsync), int'(!act_v));
      chk("blank_b", int'(bus.blank_b), int'(vis));
      chk("r_out", int'(bus.r_out), int'(c[11:8]));
      chk("g_out", int'(bus.g_out), int'(c[7:4]));
      chk("b_out", int'(bus.b_out), int'(c[3:0]));
      chk("sof", int'(bus.sof), int'(xm == 0 && ym == 0));
      chk("sol", int'(bus.sol), int'(xm == 0));
      chk("frame_cnt", int'(bus.frame_cnt), ((m / FR) + 1) % 256);
    end
  endtask

  // Store returns the colour of the address issued P enabled cycles ago.
  task automatic drive_pix();
    int idx;
    logic [11:0] c;
    idx = n - P;
    if (idx < 0) c = 12'($urandom);
    else c = mem[((idx / HT) % VT) * HT + (idx % HT)];
    bus.pix_r = c[11:8];
    bus.pix_g = c[7:4];
    bus.pix_b = c[3:0];
  endtask

  task automatic check_reset_vals();
    chk("rst_x", int'(bus.x), 0);
    chk("rst_y", int'(bus.y), 0);
    chk("rst_hsync", int'(bus.hsync), 1);
    chk("rst_vsync", int'(bus.vsync), 1);
    chk("rst_blank", int'(bus.blank_b), 0);
    chk("rst_rgb", int'({bus.r_out, bus.g_out, bus.b_out}), 0);
    chk("rst_sof", int'(bus.sof), 0);
    chk("rst_sol", int'(bus.sol), 0);
    chk("rst_frame", int'(bus.frame_cnt), 0);
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1 check_reset_vals();
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    check_all();
  endtask

  initial begin
    for (int i = 0; i < FR; i++) mem[i] = 12'($urandom);
`ifdef VGA_TEST_PATTERN_EN
    bus.pattern_sel = 1'b0;
`endif
    reset = 1'b1;
    pix_en = 1'b0;
    n = 0;
    bus.pix_r = '0;
    bus.pix_g = '0;
    bus.pix_b = '0;
    repeat (3) @(negedge clk);
    check_reset_vals();
    reset = 1'b0;
    pix_en = 1'b1;
    drive_pix();
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      if (pix_en) n++;
      @(negedge clk);
      check_all();
      if (cyc == 1000 || cyc == 5003) do_reset();
      if (cyc < 2000) pix_en = 1'b1;
      else if (cyc < 2600) pix_en = ~pix_en;
      else pix_en = ($urandom_range(7) != 0);
      drive_pix();
    end
    chk("frame_wrapped", int'(n > 256 * FR + P), 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_timing_pipe.md
Name: vga_timing_pipe

Overview:
Parametrised VGA timing generator and pixel-output pipeline. It generates the h/v counters and issues x/y read coordinates to the pixel store. It then re-aligns hsync, vsync and blank_b with the pixel data returned PIPE_LAT cycles later, and drives blanked colour to the video DAC. Replaces the fixed 640x480 controller plus the top-level blanking glue, and adds frame/line markers and clock-enable stalling.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
HSYNC_POL, 0, hsync active level (0 = active-low)
VSYNC_POL, 0, vsync active level
PIPE_LAT, 1, pix_en-qualified cycles from x/y valid to pix_r/g/b valid (0..7)
CW, 4, bits per colour channel
CNT_W, 10, counter/coordinate width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
clk  input  1  pixel clock (25.175 MHz from syspll)
reset  input  1  asynchronous, active-high reset
pix_en  input  1  clock enable; low = entire block holds state
x  output  CNT_W  current h counter (read address to pixel store)
y  output  CNT_W  current v counter
rd_active  output  1  x<H_ACTIVE && y<V_ACTIVE, undelayed
pix_r, pix_g, pix_b  input  CW each  pixel-store colour, valid PIPE_LAT enabled cycles after x/y
hsync, vsync  output  1  registered, aligned sync
blank_b  output  1  registered, high in visible region, aligned
r_out, g_out, b_out  output  CW each  colour ANDed with aligned blank_b, registered
sof  output  1  one-enabled-cycle pulse, aligned with output of pixel (0,0)
sol  output  1  one-enabled-cycle pulse, aligned with output of pixel x=0 of every line
frame_cnt  output  8  frame counter; increments at each sof; wraps 255->0

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Reset (async assert, applied immediately):
  - x=0, y=0; all delay-line stages cleared to inactive.
  - hsync=~HSYNC_POL, vsync=~VSYNC_POL.
  - blank_b=0, r/g/b_out=0, sof=0, sol=0, frame_cnt=0.
- All state advances only on rising clk with pix_en=1. With pix_en=0, every register holds and pulses hold their value. Sources of sof/sol must gate with pix_en so a pulse never spans two enabled cycles.
- Counters:
  - x increments each enabled cycle; at H_TOTAL-1, x wraps to 0 and y increments.
  - y at V_TOTAL-1 with x wrap goes to 0.
  - The first enabled cycle after reset presents x=0, y=0.
- Raw timing, evaluated combinationally from counters:
  - hs_raw active when H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vs_raw active when V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (490..491).
  - blk_raw = rd_active.
- Alignment:
  - hs_raw, vs_raw, blk_raw, sof_raw (x==0&&y==0) and sol_raw (x==0) each pass through a PIPE_LAT-stage enabled shift register.
  - One output register follows, and it also captures pix_r/g/b.
  - Total latency from counter value to outputs is PIPE_LAT+1 enabled cycles for every output. PIPE_LAT=0 means pixel data is combinational from x/y.
- Blanking: r_out = pix_r & {CW{blank_delayed}}; same for g and b. Outputs are 0 in porch and sync regardless of pix_* values.
- Polarity: output = raw_active ? POL : ~POL.
- frame_cnt increments in the same register update that asserts sof.
- Reset mid-frame: counters and pipeline clear at once. The next frame restarts at (0,0); no partial-frame sof.

Optional Feature:
VGA_TEST_PATTERN_EN:
- Defined: adds input pattern_sel (1 bit). When pattern_sel=1, the output-register colour source becomes colour bars computed from the x value delayed PIPE_LAT stages.
  - bar = xd[8:6] (64-pixel bars, repeating).
  - r = {CW{bar[2]}}, g = {CW{bar[1]}}, b = {CW{bar[0]}}.
  - Blanking is still applied; pix_* is ignored.
- Undefined: the pattern_sel port and the x delay line are absent; colour comes only from pix_*.

Test Plan:
- Reset: assert reset mid-line -> all outputs at reset values immediately. After release, first enabled cycle x=0, y=0; hsync=vsync=1 (POL=0).
- H timing (PIPE_LAT=1): count clocks from sol -> blank_b high 640 clocks; hsync low for exactly 96 clocks starting 656 clocks after sol; line period 800.
- V timing: vsync low for exactly 2 lines (1600 clocks) starting 490 lines after sof; sof period 420000 clocks; frame_cnt 0->1->2; forced wrap 255->0.
- Alignment (PIPE_LAT=3): bench memory model returns pix_r={x[3:0]} with 3-cycle latency -> r_out at visible pixel n equals n[3:0]. blank_b and r_out are simultaneous; r_out=0 during porch even with pix_r=F.
- Stall: toggle pix_en 1/0 alternately -> x advances every other clk; sof is high exactly one enabled cycle; hsync width is still 96 enabled cycles.
- Pattern (VGA_TEST_PATTERN_EN, pattern_sel=1): r/g/b_out are 0,0,0 for x 0..63, 0,0,F for x 64..127, up to F,F,F for x 448..511, then repeat; all 0 while blanked.
